// File: rtl/pdn_pipe_if.sv
// Flit bus of the 4-port deflection router: four incoming and four
// outgoing flit lanes. The bench drives through master; the router
// connects through slave.
interface pdn_pipe_if #(
    parameter int FLIT_W = 11
);
    logic [FLIT_W-1:0] north_in;
    logic [FLIT_W-1:0] south_in;
    logic [FLIT_W-1:0] east_in;
    logic [FLIT_W-1:0] west_in;
    logic [FLIT_W-1:0] north_out;
    logic [FLIT_W-1:0] south_out;
    logic [FLIT_W-1:0] east_out;
    logic [FLIT_W-1:0] west_out;

    modport master (
        output north_in, south_in, east_in, west_in,
        input  north_out, south_out, east_out, west_out
    );

    modport slave (
        input  north_in, south_in, east_in, west_in,
        output north_out, south_out, east_out, west_out
    );
endinterface

// File: rtl/pdn_pipe.sv
// Two-stage permutation deflection network for a 4-port router.
// Stage 1 (P0, P1) splits flits by axis; stage 2 (Q0 east/west,
// Q1 north/south) picks the final port. Every valid flit always leaves
// on some port, so a flit is never dropped. A flit that loses arbitration
// leaves on a port other than the one it wants, and that counts as a
// deflection.
// Flit layout: [FLIT_W-1] valid, [FLIT_W-2] golden, [1:0] port
// (0 east, 1 west, 2 north, 3 south), payload in between.
module pdn_pipe #(
    parameter int FLIT_W   = 11,
    parameter int PIPE_MID = 1,
    parameter int CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             clr_cnt,
    pdn_pipe_if.slave        ports,
    output logic [CNT_W-1:0] defl_cnt
);

    typedef logic [FLIT_W-1:0] flit_t;

    // Routing rule used by a 2x2 block
    localparam logic [1:0] MODE_S1 = 2'd0;
    localparam logic [1:0] MODE_Q0 = 2'd1;
    localparam logic [1:0] MODE_Q1 = 2'd2;

    // Chooses the lower input as the priority flit. The checks run in
    // this order: valid beats invalid, then golden beats non-golden,
    // then the tie bit decides between two equal flits.
    function automatic logic lower_wins(input flit_t up, input flit_t lo, input logic tie);
        logic res;
        if (up[FLIT_W-1] != lo[FLIT_W-1])
            res = lo[FLIT_W-1];
        else if (!up[FLIT_W-1])
            res = 1'b0;
        else if (up[FLIT_W-2] != lo[FLIT_W-2])
            res = lo[FLIT_W-2];
        else
            res = tie;
        return res;
    endfunction

    // True when the tie bit decides: both flits valid with equal golden bits.
    function automatic logic is_tie(input flit_t up, input flit_t lo);
        return up[FLIT_W-1] & lo[FLIT_W-1] & (up[FLIT_W-2] == lo[FLIT_W-2]);
    endfunction

    // One 2x2 block. It returns {out1, out0}. Invalid flits are squashed
    // to zero. The priority flit picks its output and the other flit
    // takes the remaining output.
    function automatic logic [2*FLIT_W-1:0] route(input flit_t up, input flit_t lo,
                                                  input logic tie, input logic [1:0] mode);
        flit_t win;
        flit_t los;
        logic  to_out1;
        if (lower_wins(up, lo, tie)) begin
            win = lo;
            los = up;
        end else begin
            win = up;
            los = lo;
        end
        if (!win[FLIT_W-1]) win = '0;
        if (!los[FLIT_W-1]) los = '0;
        case (mode)
            MODE_S1: to_out1 = win[1];
            MODE_Q0: to_out1 = (win[1:0] == 2'd1);
            default: to_out1 = (win[1:0] == 2'd3);
        endcase
        return to_out1 ? {win, los} : {los, win};
    endfunction

    logic tie_p0;
    logic tie_p1;
    logic tie_q0;
    logic tie_q1;

    logic [2*FLIT_W-1:0] p0_res;
    logic [2*FLIT_W-1:0] p1_res;
    logic [2*FLIT_W-1:0] q0_res;
    logic [2*FLIT_W-1:0] q1_res;

    flit_t s2_p0_o0;
    flit_t s2_p0_o1;
    flit_t s2_p1_o0;
    flit_t s2_p1_o1;

    assign p0_res = route(ports.east_in, ports.north_in, tie_p0, MODE_S1);
    assign p1_res = route(ports.west_in, ports.south_in, tie_p1, MODE_S1);

    generate
        if (PIPE_MID != 0) begin : g_mid
            flit_t mid_p0_o0;
            flit_t mid_p0_o1;
            flit_t mid_p1_o0;
            flit_t mid_p1_o1;

            // Register between the stages. It holds its value while en is low.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    mid_p0_o0 <= '0;
                    mid_p0_o1 <= '0;
                    mid_p1_o0 <= '0;
                    mid_p1_o1 <= '0;
                end else if (en) begin
                    mid_p0_o0 <= p0_res[FLIT_W-1:0];
                    mid_p0_o1 <= p0_res[2*FLIT_W-1:FLIT_W];
                    mid_p1_o0 <= p1_res[FLIT_W-1:0];
                    mid_p1_o1 <= p1_res[2*FLIT_W-1:FLIT_W];
                end
            end

            assign s2_p0_o0 = mid_p0_o0;
            assign s2_p0_o1 = mid_p0_o1;
            assign s2_p1_o0 = mid_p1_o0;
            assign s2_p1_o1 = mid_p1_o1;
        end else begin : g_comb
            assign s2_p0_o0 = p0_res[FLIT_W-1:0];
            assign s2_p0_o1 = p0_res[2*FLIT_W-1:FLIT_W];
            assign s2_p1_o0 = p1_res[FLIT_W-1:0];
            assign s2_p1_o1 = p1_res[2*FLIT_W-1:FLIT_W];
        end
    endgenerate

    assign q0_res = route(s2_p0_o0, s2_p1_o0, tie_q0, MODE_Q0);
    assign q1_res = route(s2_p0_o1, s2_p1_o1, tie_q1, MODE_Q1);

    // Each block flips its tie bit after every tie it resolves, so two
    // contenders take turns winning.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tie_p0 <= 1'b0;
            tie_p1 <= 1'b0;
            tie_q0 <= 1'b0;
            tie_q1 <= 1'b0;
        end else if (en) begin
            tie_p0 <= tie_p0 ^ is_tie(ports.east_in, ports.north_in);
            tie_p1 <= tie_p1 ^ is_tie(ports.west_in, ports.south_in);
            tie_q0 <= tie_q0 ^ is_tie(s2_p0_o0, s2_p1_o0);
            tie_q1 <= tie_q1 ^ is_tie(s2_p0_o1, s2_p1_o1);
        end
    end

    // Output registers: Q0 feeds east/west and Q1 feeds north/south.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ports.east_out  <= '0;
            ports.west_out  <= '0;
            ports.north_out <= '0;
            ports.south_out <= '0;
        end else if (en) begin
            ports.east_out  <= q0_res[FLIT_W-1:0];
            ports.west_out  <= q0_res[2*FLIT_W-1:FLIT_W];
            ports.north_out <= q1_res[FLIT_W-1:0];
            ports.south_out <= q1_res[2*FLIT_W-1:FLIT_W];
        end
    end

    logic                defl_e;
    logic                defl_w;
    logic                defl_n;
    logic                defl_s;
    logic [2:0]          defl_now;
    logic [CNT_W+2:0]    cnt_sum;
    logic [CNT_W+2:0]    cnt_max;

    assign defl_e   = ports.east_out[FLIT_W-1]  & (ports.east_out[1:0]  != 2'd0);
    assign defl_w   = ports.west_out[FLIT_W-1]  & (ports.west_out[1:0]  != 2'd1);
    assign defl_n   = ports.north_out[FLIT_W-1] & (ports.north_out[1:0] != 2'd2);
    assign defl_s   = ports.south_out[FLIT_W-1] & (ports.south_out[1:0] != 2'd3);
    assign defl_now = {2'b00, defl_e} + {2'b00, defl_w} + {2'b00, defl_n} + {2'b00, defl_s};
    assign cnt_sum  = {3'b000, defl_cnt} + {{CNT_W{1'b0}}, defl_now};
    assign cnt_max  = {3'b000, {CNT_W{1'b1}}};

    // Deflection counter. It saturates at its maximum value. A clear
    // overrides the increment and works even while en is low.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            defl_cnt <= '0;
        else if (clr_cnt)
            defl_cnt <= '0;
        else if (en)
            defl_cnt <= (cnt_sum > cnt_max) ? {CNT_W{1'b1}} : cnt_sum[CNT_W-1:0];
    end

endmodule

// File: doc/pdn_pipe.md
PDN_PIPE -- requirements
Module: pdn_pipe

Interface
REQ-001 Parameter FLIT_W, default 11, flit width in bits, minimum 4.
REQ-002 Parameter PIPE_MID, default 1; 1 inserts a register between permutation stages, 0 makes the stages combinational.
REQ-003 Parameter CNT_W, default 16, width of the deflection counter.
REQ-004 clk  input  1  sole clock; all state updates on its rising edge.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 en  input  1  pipeline advance; when low, all registers hold their values.
REQ-007 north_in, south_in, east_in, west_in  input  FLIT_W each  incoming flits.
REQ-008 north_out, south_out, east_out, west_out  output  FLIT_W each  registered outgoing flits.
REQ-009 defl_cnt  output  CNT_W  saturating count of deflected flits.
REQ-010 clr_cnt  input  1  synchronous clear of defl_cnt.

Function
REQ-011 Flit fields SHALL be: bit FLIT_W-1 valid, bit FLIT_W-2 golden, bits [1:0] desired port (0 east, 1 west, 2 north, 3 south), all other bits payload carried unchanged.
REQ-012 Stage 1 SHALL contain block P0 (upper input east_in, lower input north_in) and block P1 (upper input west_in, lower input south_in); each has out0 feeding stage-2 block Q0 and out1 feeding Q1.
REQ-013 Q0 SHALL drive east (out0) and west (out1); Q1 SHALL drive north (out0) and south (out1); Q0 upper/lower inputs come from P0.out0 and P1.out0, and Q1 upper/lower inputs from P0.out1 and P1.out1.
REQ-014 Each 2x2 block SHALL select one priority flit by: valid beats invalid; golden beats non-golden; on a tie between two valid flits, the upper input wins when the block's tie bit is 0 and the lower input wins when it is 1.
REQ-015 Each block's tie bit SHALL toggle on every enabled cycle in which that block resolves a valid-vs-valid tie; otherwise it holds.
REQ-016 Stage-1 routing: a priority flit wanting east/west SHALL take out0, and one wanting north/south SHALL take out1; the other flit takes the remaining output.
REQ-017 Stage-2 routing: a priority flit SHALL take the output matching its desired port; if that port is not in the block's pair, it takes out0; the other flit takes the remaining output.
REQ-018 Invalid flits SHALL propagate as all-zero words; an output with no valid flit drives 0.
REQ-019 A flit is deflected when it is valid at an output whose port index differs from bits [1:0].
REQ-020 Latency SHALL be 2 enabled cycles (input to output) when PIPE_MID=1 and 1 when PIPE_MID=0.
REQ-021 Throughput SHALL be four flits per enabled cycle with no back-pressure; valid flits SHALL never be dropped or duplicated.
REQ-022 defl_cnt SHALL add, each enabled cycle, the number of deflected flits (0..4) currently at the outputs, saturating at 2^CNT_W-1.
REQ-023 clr_cnt=1 SHALL set defl_cnt to 0 on that edge, taking priority over increment, and SHALL act regardless of en.
REQ-024 The golden bit SHALL be carried unchanged; the block never sets or clears it.

Reset
REQ-025 rst_n low SHALL immediately clear all output and mid-stage registers, defl_cnt and all tie bits to 0, including mid-operation; in-flight flits are discarded.
REQ-026 The first flits presented after reset deassertion SHALL appear after the REQ-020 latency.

Verification
REQ-027 FLIT_W=11, PIPE_MID=1: east_in=0x402 (to N), north_in=0x400 (to E), west_in=0x403 (to S), south_in=0x401 (to W) -> two cycles later east_out=0x400, west_out=0x401, north_out=0x402, south_out=0x403; defl_cnt stays 0.
REQ-028 north_in=0x600 (golden, to E), east_in=0x400 (to E), others 0 -> east_out=0x600, north_out=0x400; defl_cnt=1 one cycle after the outputs appear.
REQ-029 After reset, apply east_in=0x400 and north_in=0x404 (both to E, non-golden) on three consecutive cycles -> east_out payload alternates 0x400, 0x404, 0x400 because the P0 tie bit toggles; defl_cnt=3.
REQ-030 Hold en=0 for 3 cycles with a flit mid-pipe -> outputs and defl_cnt frozen; the flit emerges on the first enabled cycle after en returns high.
REQ-031 Pulse rst_n low asynchronously between edges with the pipe full -> outputs and defl_cnt become 0 without a clock edge; no stale flit emerges later.
REQ-032 CNT_W=2, with three deflections per cycle -> defl_cnt=3 and holds at 3; clr_cnt=1 -> 0 on the next edge.
